// File: rtl/hash_target_checker.sv
// Compact-difficulty target check behind the SHA stage: reports the first winning nonce per block.
// Optional HASH_CHECK_STATS_EN adds checkedCount/winCount statistics outputs.
module hash_target_checker #(
    parameter int NONCE_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validIn,
    input  logic                  newBlockIn,
    input  logic [255:0]          hash,
    input  logic [31:0]           difficulty,
    output logic                  resultValid,
    input  logic                  resultAck,
    output logic [NONCE_BITS-1:0] resultNonce,
    output logic [255:0]          resultHash,
    output logic                  missed,
    output logic                  exhausted
`ifdef HASH_CHECK_STATS_EN
    ,
    output logic [31:0]           checkedCount,
    output logic [15:0]           winCount
`endif
);

    logic [NONCE_BITS-1:0] cnt_reg;
    logic [NONCE_BITS-1:0] beat_idx;
    logic [255:0]          target;
    logic [255:0]          mant;
    logic [7:0]            expo;

    logic                  s1_valid_reg;
    logic                  s1_new_reg;
    logic [NONCE_BITS-1:0] s1_idx_reg;
    logic [255:0]          s1_hash_reg;
    logic [255:0]          s1_target_reg;

    logic                  rv_reg, rv_next;
    logic [NONCE_BITS-1:0] nonce_reg, nonce_next;
    logic [255:0]          rhash_reg, rhash_next;
    logic                  found_reg, found_next;
    logic                  missed_reg, missed_next;
    logic                  exh_reg, exh_next;

    logic                  win;
    logic                  found_eff;
    logic                  take;
    logic                  capture;

    assign beat_idx = newBlockIn ? '0 : cnt_reg;

    // Target expansion: byte-granular shift of the 24-bit mantissa.
    always_comb begin
        mant   = {232'b0, difficulty[23:0]};
        expo   = difficulty[31:24];
        target = '1;
        if (expo <= 8'd3)
            target = mant >> {(8'd3 - expo), 3'b000};
        else if (expo <= 8'd32)
            target = mant << {(expo - 8'd3), 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_new_reg    <= 1'b0;
            s1_idx_reg    <= '0;
            s1_hash_reg   <= '0;
            s1_target_reg <= '0;
        end else begin
            s1_valid_reg <= validIn;
            if (validIn) begin
                s1_new_reg    <= newBlockIn;
                s1_idx_reg    <= beat_idx;
                s1_hash_reg   <= hash;
                s1_target_reg <= target;
                cnt_reg       <= beat_idx + 1'b1;
            end
        end
    end

    // A newBlock beat clears the found flag before its own win is evaluated.
    assign win       = s1_valid_reg && (s1_hash_reg < s1_target_reg);
    assign found_eff = (s1_valid_reg && s1_new_reg) ? 1'b0 : found_reg;
    assign take      = win && !found_eff;
    assign capture   = take && (!rv_reg || resultAck);

    always_comb begin
        rv_next     = rv_reg;
        nonce_next  = nonce_reg;
        rhash_next  = rhash_reg;
        found_next  = found_eff;
        missed_next = missed_reg;
        exh_next    = s1_valid_reg && (&s1_idx_reg) && !win && !found_eff;
        if (resultAck)
            rv_next = 1'b0;
        if (take) begin
            found_next = 1'b1;
            if (capture) begin
                rv_next    = 1'b1;
                nonce_next = s1_idx_reg;
                rhash_next = s1_hash_reg;
            end else begin
                missed_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rv_reg     <= 1'b0;
            nonce_reg  <= '0;
            rhash_reg  <= '0;
            found_reg  <= 1'b0;
            missed_reg <= 1'b0;
            exh_reg    <= 1'b0;
        end else begin
            rv_reg     <= rv_next;
            nonce_reg  <= nonce_next;
            rhash_reg  <= rhash_next;
            found_reg  <= found_next;
            missed_reg <= missed_next;
            exh_reg    <= exh_next;
        end
    end

    assign resultValid = rv_reg;
    assign resultNonce = nonce_reg;
    assign resultHash  = rhash_reg;
    assign missed      = missed_reg;
    assign exhausted   = exh_reg;

`ifdef HASH_CHECK_STATS_EN
    logic [31:0] checked_reg;
    logic [15:0] wins_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            checked_reg <= '0;
            wins_reg    <= '0;
        end else begin
            if (s1_valid_reg)
                checked_reg <= checked_reg + 32'd1;
            if (capture && (wins_reg != 16'hFFFF))
                wins_reg <= wins_reg + 16'd1;
        end
    end

    assign checkedCount = checked_reg;
    assign winCount     = wins_reg;
`endif

endmodule

// File: tb/tb_hash_target_checker.sv
// Directed bench for hash_target_checker with a cycle-level behavioural model and literal spot checks.
module tb_hash_target_checker;

    localparam int NB      = 4;
    localparam int IDX_MAX = (1 << NB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          validIn = 1'b0;
    logic          newBlockIn = 1'b0;
    logic          resultAck = 1'b0;
    logic [255:0]  hash = '0;
    logic [31:0]   difficulty = '0;
    logic          resultValid;
    logic [NB-1:0] resultNonce;
    logic [255:0]  resultHash;
    logic          missed;
    logic          exhausted;
`ifdef HASH_CHECK_STATS_EN
    logic [31:0]   checkedCount;
    logic [15:0]   winCount;
`endif

    always #5 clk = ~clk;

    hash_target_checker #(.NONCE_BITS(NB)) dut (
        .clk(clk),
        .rst(rst),
        .validIn(validIn),
        .newBlockIn(newBlockIn),
        .hash(hash),
        .difficulty(difficulty),
        .resultValid(resultValid),
        .resultAck(resultAck),
        .resultNonce(resultNonce),
        .resultHash(resultHash),
        .missed(missed),
        .exhausted(exhausted)
`ifdef HASH_CHECK_STATS_EN
        ,
        .checkedCount(checkedCount),
        .winCount(winCount)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc_no = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // Target from the compact form by repeated byte scaling.
    function automatic logic [255:0] expand(input logic [31:0] d);
        int e;
        logic [255:0] t;
        e = int'(d[31:24]);
        t = {232'b0, d[23:0]};
        if (e >= 33) return '1;
        for (int i = e; i < 3; i++) t = t / 256;
        for (int i = 3; i < e; i++) t = t * 256;
        return t;
    endfunction

    // Model state: expected outputs plus the beat waiting for evaluation.
    logic         e_rv = 0, e_missed = 0, e_exh = 0, m_found = 0;
    int           e_nonce = 0, m_cnt = 0, pidx = 0;
    logic [255:0] e_hash = '0, phash = '0, ptarget = '0;
    logic         pv = 0, pnew = 0, m_win = 0, m_fnd = 0, m_free = 0;
    logic [31:0]  e_checked = '0;
    logic [15:0]  e_wins = '0;

    always @(posedge clk) begin
        cyc_no++;
        if (!rst) begin
            e_rv = 0; e_missed = 0; e_exh = 0; m_found = 0;
            e_nonce = 0; e_hash = '0; m_cnt = 0; pv = 0;
            e_checked = '0; e_wins = '0;
        end else begin
            m_win  = pv && (phash < ptarget);
            m_fnd  = (pv && pnew) ? 1'b0 : m_found;
            m_free = !e_rv || resultAck;
            e_exh  = pv && (pidx == IDX_MAX) && !m_win && !m_fnd;
            if (pv) e_checked = e_checked + 1;
            if (resultAck) e_rv = 0;
            m_found = m_fnd;
            if (m_win && !m_fnd) begin
                m_found = 1;
                if (m_free) begin
                    e_rv = 1; e_nonce = pidx; e_hash = phash;
                    if (e_wins != 16'hFFFF) e_wins = e_wins + 1;
                end else begin
                    e_missed = 1;
                end
            end
            pv = validIn;
            if (validIn) begin
                pidx    = newBlockIn ? 0 : m_cnt;
                m_cnt   = (pidx + 1) % (1 << NB);
                pnew    = newBlockIn;
                phash   = hash;
                ptarget = expand(difficulty);
            end
        end
    end

    int exh_pulses = 0;
    int last_exh_cyc = -1;

    always @(negedge clk) begin
        if (cyc_no > 0) begin
            check("resultValid", 256'(resultValid), 256'(e_rv));
            check("missed", 256'(missed), 256'(e_missed));
            check("exhausted", 256'(exhausted), 256'(e_exh));
            if (e_rv) begin
                check("resultNonce", 256'(resultNonce), 256'(e_nonce));
                check("resultHash", resultHash, e_hash);
            end
`ifdef HASH_CHECK_STATS_EN
            check("checkedCount", 256'(checkedCount), 256'(e_checked));
            check("winCount", 256'(winCount), 256'(e_wins));
`endif
            if (exhausted) begin
                exh_pulses++;
                last_exh_cyc = cyc_no;
            end
        end
    end

    task automatic cyc(input logic v, input logic nb, input logic [255:0] h, input logic ack);
        validIn    = v;
        newBlockIn = nb;
        hash       = h;
        resultAck  = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    logic [255:0] all_ones;
    logic [255:0] t1;
    int k;

    initial begin
        all_ones = '1;
        t1 = '0;
        t1[223:208] = 16'hFFFF;

        // Reset
        rst = 0;
        idle(2);
        check("rst_valid", 256'(resultValid), 256'd0);
        check("rst_missed", 256'(missed), 256'd0);
        check("rst_exh", 256'(exhausted), 256'd0);
        check("rst_nonce", 256'(resultNonce), 256'd0);
        check("rst_hash", resultHash, 256'd0);
        rst = 1;

        // Target 0x1d00ffff and two-cycle latency
        difficulty = 32'h1d00ffff;
        cyc(1, 1, all_ones, 0);
        for (int i = 1; i <= 4; i++) cyc(1, 0, all_ones, 0);
        k = cyc_no;
        cyc(1, 0, 256'd1, 0);
        check("t1_not_early", 256'(resultValid), 256'd0);
        idle(1);
        check("t1_latency_cyc", 256'(cyc_no), 256'(k + 2));
        check("t1_valid", 256'(resultValid), 256'd1);
        check("t1_nonce", 256'(resultNonce), 256'd5);
        check("t1_hash", resultHash, 256'd1);
        idle(3);
        check("t1_held", 256'(resultValid), 256'd1);
        cyc(0, 0, '0, 1);
        check("t1_acked", 256'(resultValid), 256'd0);

        // Boundary at the large target: equality loses, one below wins
        cyc(1, 1, t1, 0);
        cyc(1, 0, t1 - 1, 0);
        idle(1);
        check("t1b_nonce", 256'(resultNonce), 256'd1);
        check("t1b_hash", resultHash, t1 - 1);
        cyc(0, 0, '0, 1);

        // Small exponent, strict compare
        difficulty = 32'h02123456;
        cyc(1, 1, 256'h1234, 0);
        cyc(1, 0, 256'h1233, 0);
        idle(1);
        check("t2_valid", 256'(resultValid), 256'd1);
        check("t2_nonce", 256'(resultNonce), 256'd1);
        check("t2_hash", resultHash, 256'h1233);
        cyc(0, 0, '0, 1);

        // Exponent above 32 saturates the target
        difficulty = 32'h21000000;
        cyc(1, 1, all_ones, 0);
        cyc(1, 0, all_ones - 1, 0);
        idle(1);
        check("t2s_nonce", 256'(resultNonce), 256'd1);
        check("t2s_hash", resultHash, all_ones - 1);
        cyc(0, 0, '0, 1);
        idle(1);

        // Found flag, ack-cycle capture, missed
        difficulty = 32'h1d00ffff;
        cyc(1, 1, all_ones, 0);
        cyc(1, 0, all_ones, 0);
        cyc(1, 0, 256'd1, 0);
        cyc(1, 0, all_ones, 0);
        cyc(1, 0, 256'd2, 0);
        idle(2);
        check("t3a_nonce", 256'(resultNonce), 256'd2);
        check("t3a_hash", resultHash, 256'd1);
        check("t3a_missed", 256'(missed), 256'd0);
        cyc(1, 1, 256'd3, 0);
        cyc(0, 0, '0, 1);
        check("t3b_valid", 256'(resultValid), 256'd1);
        check("t3b_nonce", 256'(resultNonce), 256'd0);
        check("t3b_hash", resultHash, 256'd3);
        check("t3b_missed", 256'(missed), 256'd0);
        cyc(1, 1, 256'd4, 0);
        idle(2);
        check("t3c_missed", 256'(missed), 256'd1);
        check("t3c_hash", resultHash, 256'd3);
        cyc(0, 0, '0, 1);
        rst = 0;
        idle(1);
        rst = 1;

        // Exhaustion with a zero target and wrap to index 0
        difficulty = 32'h03000000;
        exh_pulses = 0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) k = cyc_no;
            cyc(1, (i == 0), '0, 0);
        end
        cyc(1, 0, '0, 0);
        idle(3);
        check("t4_pulses", 256'(exh_pulses), 256'd1);
        check("t4_pulse_cyc", 256'(last_exh_cyc), 256'(k + 2));

        // Reset with a pending result and two beats in flight
        difficulty = 32'h1d00ffff;
        cyc(1, 1, 256'd1, 0);
        idle(2);
        check("t5_pre_valid", 256'(resultValid), 256'd1);
        cyc(1, 1, 256'd1, 0);
        rst = 0;
        cyc(1, 0, 256'd2, 0);
        rst = 1;
        check("t5_valid", 256'(resultValid), 256'd0);
        check("t5_missed", 256'(missed), 256'd0);
        check("t5_nonce", 256'(resultNonce), 256'd0);
        check("t5_hash", resultHash, 256'd0);
        idle(3);
        check("t5_no_ghost", 256'(resultValid), 256'd0);
        cyc(1, 0, 256'd7, 0);
        idle(1);
        check("t5_new_valid", 256'(resultValid), 256'd1);
        check("t5_new_nonce", 256'(resultNonce), 256'd0);
        check("t5_new_hash", resultHash, 256'd7);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hash_target_checker.md
Name: hash_target_checker

Overview:
- Sits directly downstream of the SHA stage and consumes its validOut/newBlockOut/hash/difficulty stream.
- Expands the 32-bit compact difficulty into a 256-bit target and tests each hash for hash < target.
- Tracks the nonce index of every beat within the current block and reports the first winning nonce per block through a held valid/ack handshake.
- Flags dropped wins and exhausted nonce ranges.

Parameters:
- NONCE_BITS, 32, width of the per-block nonce index counter and of resultNonce.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- validIn  in  1  hash/difficulty beat valid
- newBlockIn  in  1  beat is the first of a new block; ignored when validIn=0
- hash  in  256  hash as an unsigned integer, bit 255 = MSB
- difficulty  in  32  compact target: [31:24] exponent E, [23:0] mantissa M (unsigned; bit 23 is not a sign)
- resultValid  out  1  a winning result is held
- resultAck  in  1  consumer accepts the result
- resultNonce  out  NONCE_BITS  nonce index of the winning beat
- resultHash  out  256  winning hash
- missed  out  1  sticky: a first-win of some block was dropped because a result was still pending
- exhausted  out  1  one-cycle pulse: a block used its full nonce range without a win

Behaviour:
- Reset (rst=0 at a clock edge):
  - all outputs 0; nonce counter 0; both pipeline stage valids 0; found flag 0.
  - Takes priority over all other events, including a mid-block reset; no partial state survives it.
- Nonce index:
  - A beat with validIn=1 and newBlockIn=1 gets index 0.
  - Each subsequent valid beat gets previous index + 1, modulo 2^NONCE_BITS (wraps).
  - Invalid cycles do not advance the counter.
  - Before the first newBlock beat after reset, indexing starts at 0.
- Stage 1 (registered): captures valid, newBlock, index and hash, plus the expanded target T:
  - E <= 3: T = M >> 8*(3-E).
  - 4 <= E <= 32: T = M << 8*(E-3), truncated to 256 bits.
  - E >= 33: T = 2^256-1.
- Stage 2 (registered): win = valid && (hash < T). The comparison is strict, so equality does not win.
- Latency: a beat presented in cycle N updates result/flags in cycle N+2. Throughput is one beat per cycle with no stalls; the block never backpressures.
- Found flag:
  - Cleared by a newBlock beat at stage 2 before that same beat is evaluated.
  - Set when a win is taken.
  - A win with found=1 is silently ignored; it is neither recorded nor counted as missed.
- Result capture: a win with found=0:
  - If resultValid=0: load resultNonce/resultHash, set resultValid, set found.
  - If resultValid=1 and the result is not acked this cycle: drop the win, set found, set missed (sticky until reset).
- Handshake:
  - resultValid holds and outputs stay stable until a cycle with resultAck=1. That cycle clears resultValid at the next edge.
  - If a new win is captured in the ack cycle, load the new result and keep resultValid=1. Ack frees the slot for a same-cycle win, so that win is not missed.
  - resultAck while resultValid=0 has no effect.
- exhausted: pulses for one cycle when a stage-2 beat with index 2^NONCE_BITS-1 does not win and found=0.
- A pending result survives a new block.

Optional Feature:
- Macro: HASH_CHECK_STATS_EN.
- When defined:
  - Adds output checkedCount[31:0], the count of valid beats that have reached stage 2 since reset, wrapping at 2^32.
  - Adds output winCount[15:0], the count of captured results (excludes dropped and ignored wins), saturating at 0xFFFF.
  - Both counters reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Target and latency: difficulty=0x1d00ffff (T=0x0000_0000_FFFF followed by 208 zero bits). One newBlock beat, then beats 1..5; beat 5 hash=1, the rest all-ones. Required: resultValid rises exactly 2 cycles after beat 5 with resultNonce=5 and resultHash=1, and holds until resultAck.
- Small exponent and strict compare: difficulty=0x02123456 (T=0x1234). hash=0x1234 -> no win. hash=0x1233 -> win.
- Found flag and missed:
  - Block A wins at index 2 and index 4, no ack -> only nonce 2 held, missed stays 0.
  - New block B wins at index 0 while A is still unacked -> missed=1, result still nonce 2.
  - Ack in the same cycle as B's win arrives -> result becomes B's nonce 0, missed not set by that win.
- Exhaustion: NONCE_BITS=4, difficulty=0x03000000 (T=0), 16 valid beats starting with newBlock -> exhausted pulses once, 2 cycles after beat index 15. A 17th beat wraps to index 0 with no second pulse.
- Reset mid-operation: rst=0 for one cycle while resultValid=1 and two beats are in the pipeline -> all outputs 0 next cycle, in-flight beats never produce a result, and the next valid beat without newBlock gets index 0.
